alu_word_sequencer: RTL
=======================

# alu_word_sequencer

Multi-word arithmetic/logic sequencer that drives the team's combinational 8-bit ALU from the operand side. It accepts one wide request of Words×DataWidth bits over a valid/ready handshake and issues one ALU word operation per clock, least-significant word first. It chains carry between words, captures each result word and the final flags, and returns the wide result over a second valid/ready handshake. It sits between instruction decode/execute control and the ALU instance in the parent datapath.

## Interface
- DataWidth, 8, ALU word width in bits
- FlagBits, 4, flag vector width; bit 0 is Z, bit 1 is C, bit 2 is N, bit 3 is V
- Words, 4, words per operand; must be at least 1
- Clk  input  1  single clock; all state changes on the rising edge
- Reset  input  1  asynchronous, active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  high only in IDLE while Reset is low
- ReqOp  input  4  operation: Add 0000, Sub 0001, And 0010, Or 0011, Xor 0100
- ReqA, ReqB  input  Words×DataWidth  operands
- ReqCarry  input  1  carry-in; used by Add only
- AluA, AluB  output  DataWidth  word operands driven to the ALU
- AluFuncOp  output  4  ALU operation code
- AluIFlags  output  FlagBits  ALU input flags; only the C bit is ever non-zero
- AluY  input  DataWidth  ALU result word
- AluOFlags  input  FlagBits  ALU flags for the current word
- RspValid  output  1  result available
- RspReady  input  1  consumer accepts the result
- RspY  output  Words×DataWidth  wide result
- RspFlags  output  FlagBits  final {V,N,C,Z}
- RspErr  output  1  high when the request carried an unsupported ReqOp

## Operation
- States:
  - IDLE: ReqReady=1.
  - RUN: a word index counts 0..Words-1.
  - DONE: RspValid=1.
- IDLE→RUN on ReqValid&&ReqReady with a supported op. The accepting edge registers ReqOp, ReqA, ReqB and the carry seed, and clears the word index.
- IDLE→DONE on acceptance of an unsupported op. Result: RspErr=1, RspY=0, RspFlags=0. The ALU is not exercised.
- RUN, each cycle at word index i:
  - AluA = A word i.
  - Add: AluB = B word i, AluFuncOp = Add_OP, carry-in = ReqCarry for i=0, otherwise the carry captured from the previous word.
  - Sub: AluB = ~(B word i), AluFuncOp = Add_OP, carry-in = 1 for i=0, otherwise the chained carry. C means "no borrow". The ALU's Sub_OP is never issued.
  - And/Or/Xor: AluB = B word i, AluFuncOp = ReqOp, AluIFlags = 0.
  - Each edge captures AluY into result word i and AluOFlags[C] into the carry register.
- Z accumulation: Z is the AND of every word's Z.
- Last word (i=Words-1): captures N, V and C. For logic ops, V is forced to 0; C comes from the ALU and is 0. The state then moves to DONE.
- DONE→IDLE on RspValid&&RspReady. RspY, RspFlags and RspErr hold stable until then.
- Any ReqValid outside IDLE is ignored and not queued.
- Outside RUN: AluA=0, AluB=0, AluFuncOp=Add_OP, AluIFlags=0.
- Width rules:
  - Word i occupies bits [i×DataWidth+DataWidth-1 : i×DataWidth].
  - The word index is max(1, clog2(Words)) bits wide.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - RspValid, RspErr, RspY, RspFlags, the carry register and the word index go to 0.
  - ReqReady is 0 while Reset is high and 1 in the first cycle after release.
- Latency for supported ops: RspValid rises exactly Words edges after the accepting edge. Words=1 gives 1 edge.
- Latency for unsupported ops: RspValid rises 1 edge after acceptance.
- Handshake: the DONE→IDLE edge leaves ReqReady high in the following cycle. Minimum request spacing is Words+2 cycles with RspReady tied high. There is no overlap of request and response.
- The ALU path is combinational within a cycle. The AluY/AluOFlags input-to-capture path is single-cycle, with no internal pipelining.
- Reset during RUN or DONE aborts the operation. The partial result is discarded and no RspValid pulse is produced.

## Structure
- Shared package alu_pkg, used by both the ALU and this sequencer:
  - opcode constants Add_OP, Sub_OP, And_OP, Or_OP, Xor_OP;
  - flag bit indices ZeroFlag, CarryFlag, NegFlag, OverFlag;
  - the state encoding.
- No sub-module. The ALU is instantiated alongside the sequencer in the parent, not inside it.
- The bench instantiates the real ALU with AluA/AluB/AluFuncOp/AluIFlags connected to it.

## Test plan
- Add carry chain: Add 0x000000FF + 0x00000001, ReqCarry=0 → RspY=0x00000100, flags Z0 C0 N0 V0, RspValid on the 4th edge after accept.
- Add wrap: Add 0xFFFFFFFF + 0x00000001 → RspY=0x00000000, Z1 C1 N0 V0.
- Add carry-in: Add 0x7FFFFFFF + 0x00000000, ReqCarry=1 → RspY=0x80000000, N1 V1 C0.
- Subtract borrow: Sub 0x00000000 - 0x00000001 → 0xFFFFFFFF, C0 N1 V0.
- Subtract overflow: Sub 0x80000000 - 0x00000001 → 0x7FFFFFFF, C1 V1 N0.
- Logic V mask: Xor 0x80000000 ^ 0x80000000 → RspY=0, Z1, V0 (forced to 0 even though the ALU reports V=1); C0.
- Backpressure: hold RspReady low for 5 cycles after RspValid → RspY/RspFlags stable, ReqReady 0, and a ReqValid pulse meanwhile is ignored; ReqReady=1 the cycle after the response handshake.
- Reset and error:
  - Assert Reset after word 1 of an Add → RspValid 0 immediately, with no stale response.
  - The next Add 0x00000002 + 0x00000003 returns 0x00000005.
  - ReqOp=1000 → RspErr=1, RspY=0, RspValid 1 edge after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the multi-word sequencer that drives it:
// opcodes, flag bit positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] Add_OP = 4'b0000;
    localparam logic [3:0] Sub_OP = 4'b0001;
    localparam logic [3:0] And_OP = 4'b0010;
    localparam logic [3:0] Or_OP  = 4'b0011;
    localparam logic [3:0] Xor_OP = 4'b0100;

    localparam int ZeroFlag  = 0;
    localparam int CarryFlag = 1;
    localparam int NegFlag   = 2;
    localparam int OverFlag  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    function automatic logic is_logic_op(input logic [3:0] op);
        return (op == And_OP) || (op == Or_OP) || (op == Xor_OP);
    endfunction

    function automatic logic is_supported_op(input logic [3:0] op);
        return (op == Add_OP) || (op == Sub_OP) || is_logic_op(op);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational word ALU. Add honours the incoming carry flag; V is computed from the
// operand and result sign bits for every operation, so logic ops may report V=1.
module alu
    import alu_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int FlagBits  = 4
) (
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic [3:0]           func_op,
    input  logic [FlagBits-1:0]  i_flags,
    output logic [DataWidth-1:0] y,
    output logic [FlagBits-1:0]  o_flags
);

    logic [DataWidth:0]   sum;
    logic [DataWidth-1:0] b_eff;

    always_comb begin
        sum   = '0;
        b_eff = b;
        case (func_op)
            Add_OP: sum = {1'b0, a} + {1'b0, b} + {{DataWidth{1'b0}}, i_flags[CarryFlag]};
            Sub_OP: begin
                b_eff = ~b;
                sum   = {1'b0, a} + {1'b0, ~b} + {{DataWidth{1'b0}}, 1'b1};
            end
            And_OP: sum = {1'b0, a & b};
            Or_OP:  sum = {1'b0, a | b};
            Xor_OP: sum = {1'b0, a ^ b};
            default: sum = '0;
        endcase

        y                 = sum[DataWidth-1:0];
        o_flags           = '0;
        o_flags[ZeroFlag]  = (y == '0);
        o_flags[CarryFlag] = sum[DataWidth];
        o_flags[NegFlag]   = y[DataWidth-1];
        o_flags[OverFlag]  = (a[DataWidth-1] == b_eff[DataWidth-1]) && (y[DataWidth-1] != a[DataWidth-1]);
    end

endmodule

// File: rtl/alu_word_sequencer.sv
// Drives the word ALU one word per clock, LSW first, chaining carry between words and
// collecting the wide result and final {V,N,C,Z} behind a valid/ready response.
module alu_word_sequencer
    import alu_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int FlagBits  = 4,
    parameter int Words     = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       ReqValid,
    output logic                       ReqReady,
    input  logic [3:0]                 ReqOp,
    input  logic [Words*DataWidth-1:0] ReqA,
    input  logic [Words*DataWidth-1:0] ReqB,
    input  logic                       ReqCarry,
    output logic [DataWidth-1:0]       AluA,
    output logic [DataWidth-1:0]       AluB,
    output logic [3:0]                 AluFuncOp,
    output logic [FlagBits-1:0]        AluIFlags,
    input  logic [DataWidth-1:0]       AluY,
    input  logic [FlagBits-1:0]        AluOFlags,
    output logic                       RspValid,
    input  logic                       RspReady,
    output logic [Words*DataWidth-1:0] RspY,
    output logic [FlagBits-1:0]        RspFlags,
    output logic                       RspErr
);

    localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

    seq_state_e                 state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [3:0]                 op_q, op_d;
    logic [Words*DataWidth-1:0] a_q, a_d;
    logic [Words*DataWidth-1:0] b_q, b_d;
    logic [Words*DataWidth-1:0] y_q, y_d;
    logic [FlagBits-1:0]        flags_q, flags_d;
    logic                       carry_q, carry_d;
    logic                       z_acc_q, z_acc_d;
    logic                       err_q, err_d;

    logic                       accept;
    logic                       last_word;
    logic [DataWidth-1:0]       a_word;
    logic [DataWidth-1:0]       b_word;

    assign accept    = (state_q == IDLE) && ReqValid;
    assign last_word = (idx_q == LastIdx);
    assign a_word    = a_q[idx_q*DataWidth +: DataWidth];
    assign b_word    = b_q[idx_q*DataWidth +: DataWidth];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= Add_OP;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            flags_q <= '0;
            carry_q <= 1'b0;
            z_acc_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            carry_q <= carry_d;
            z_acc_q <= z_acc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_supported_op(ReqOp) ? RUN : DONE;
            RUN:  if (last_word) state_d = DONE;
            DONE: if (RspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The carry register is seeded at acceptance, so every word simply uses carry_q.
    always_comb begin
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        flags_d = flags_q;
        carry_d = carry_q;
        z_acc_d = z_acc_q;
        err_d   = err_q;
        if (accept) begin
            idx_d   = '0;
            op_d    = ReqOp;
            a_d     = ReqA;
            b_d     = ReqB;
            y_d     = '0;
            flags_d = '0;
            z_acc_d = 1'b1;
            err_d   = !is_supported_op(ReqOp);
            carry_d = (ReqOp == Add_OP) ? ReqCarry : (ReqOp == Sub_OP);
        end else if (state_q == RUN) begin
            y_d[idx_q*DataWidth +: DataWidth] = AluY;
            carry_d = AluOFlags[CarryFlag];
            z_acc_d = z_acc_q & AluOFlags[ZeroFlag];
            idx_d   = idx_q + 1'b1;
            if (last_word) begin
                idx_d              = '0;
                flags_d[ZeroFlag]  = z_acc_d;
                flags_d[CarryFlag] = AluOFlags[CarryFlag];
                flags_d[NegFlag]   = AluOFlags[NegFlag];
                flags_d[OverFlag]  = is_logic_op(op_q) ? 1'b0 : AluOFlags[OverFlag];
            end
        end
    end

    // Subtract is issued as A + ~B with carry-in 1, so C reads as "no borrow".
    always_comb begin
        AluA      = '0;
        AluB      = '0;
        AluFuncOp = Add_OP;
        AluIFlags = '0;
        if (state_q == RUN) begin
            AluA = a_word;
            if (is_logic_op(op_q)) begin
                AluB      = b_word;
                AluFuncOp = op_q;
            end else begin
                AluB                 = (op_q == Sub_OP) ? ~b_word : b_word;
                AluIFlags[CarryFlag] = carry_q;
            end
        end
    end

    assign ReqReady = (state_q == IDLE) && !Reset;
    assign RspValid = (state_q == DONE);
    assign RspY     = y_q;
    assign RspFlags = flags_q;
    assign RspErr   = err_q;

endmodule
